// File: rtl/spi_ram_master.sv
// SPI mode-0 master issuing cmd / 32-bit address / [dummy] / data frames.
// Byte-stream side: tx handshake for writes, rx pulse for reads, done pulse at frame end.
module spi_ram_master #(
  parameter int C_CLK_DIV  = 2,
  parameter int C_LEN_BITS = 16,
  parameter int C_GAP      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  rnw_i,
  input  logic [31:0]           addr_i,
  input  logic [C_LEN_BITS-1:0] len_i,
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [7:0]            rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  csn_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);
  localparam int CW = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;
  localparam int GW = $clog2(C_GAP + 2);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP} state_t;

  state_t                state, n_state;
  logic [CW-1:0]         cnt, n_cnt;
  logic                  sclk_q, n_sclk;
  logic [2:0]            bit_cnt, n_bit;
  logic [1:0]            ab_cnt, n_ab;
  logic [C_LEN_BITS-1:0] len_cnt, n_len;
  logic [31:0]           addr_q, n_addr;
  logic                  rnw_q, n_rnw;
  logic [7:0]            tx_sh, n_tx;
  logic [7:0]            rx_sh, n_rx;
  logic [7:0]            rx_data_q, n_rxd;
  logic                  rx_valid_q, n_rxv;
  logic                  miso_q;
  logic [GW-1:0]         gap_cnt, n_gap;
  logic                  wait_q, n_wait;
  logic                  tx_ready;
  logic                  edge_t, next_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sclk_q     <= 1'b0;
      bit_cnt    <= '0;
      ab_cnt     <= '0;
      len_cnt    <= '0;
      addr_q     <= '0;
      rnw_q      <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      gap_cnt    <= '0;
      wait_q     <= 1'b0;
    end else begin
      state      <= n_state;
      cnt        <= n_cnt;
      sclk_q     <= n_sclk;
      bit_cnt    <= n_bit;
      ab_cnt     <= n_ab;
      len_cnt    <= n_len;
      addr_q     <= n_addr;
      rnw_q      <= n_rnw;
      tx_sh      <= n_tx;
      rx_sh      <= n_rx;
      rx_data_q  <= n_rxd;
      rx_valid_q <= n_rxv;
      miso_q     <= miso_i;
      gap_cnt    <= n_gap;
      wait_q     <= n_wait;
    end
  end

  assign edge_t = (cnt == CW'(C_CLK_DIV - 1));

  always_comb begin
    n_state   = state;
    n_cnt     = cnt;
    n_sclk    = sclk_q;
    n_bit     = bit_cnt;
    n_ab      = ab_cnt;
    n_len     = len_cnt;
    n_addr    = addr_q;
    n_rnw     = rnw_q;
    n_tx      = tx_sh;
    n_rx      = rx_sh;
    n_rxd     = rx_data_q;
    n_rxv     = 1'b0;
    n_gap     = gap_cnt;
    n_wait    = wait_q;
    tx_ready  = 1'b0;
    next_data = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          n_rnw  = rnw_i;
          n_addr = addr_i;
          n_len  = len_i;
          n_cnt  = '0;
          n_sclk = 1'b0;
          n_bit  = '0;
          n_ab   = '0;
          n_wait = 1'b0;
          n_gap  = '0;
          if (len_i == '0) n_state = S_GAP;
          else begin
            n_state = S_CMD;
            n_tx    = {7'b0, rnw_i};
          end
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (state == S_DATA && wait_q) begin
          // write stall: sclk parked low until the source offers the next byte
          if (tx_valid_i) begin
            tx_ready = 1'b1;
            n_tx     = tx_data_i;
            n_len    = len_cnt - 1'b1;
            n_wait   = 1'b0;
            n_cnt    = '0;
          end
        end else begin
          n_cnt = edge_t ? '0 : cnt + 1'b1;
          if (edge_t && !sclk_q) begin
            n_sclk = 1'b1;
            n_rx   = {rx_sh[6:0], miso_q};
            if (state == S_DATA && rnw_q && bit_cnt == 3'd7) begin
              n_rxd = {rx_sh[6:0], miso_q};
              n_rxv = 1'b1;
            end
          end else if (edge_t && sclk_q) begin
            n_sclk = 1'b0;
            n_bit  = bit_cnt + 3'd1;
            n_tx   = {tx_sh[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              case (state)
                S_CMD: begin
                  n_state = S_ADDR;
                  n_ab    = '0;
                  n_tx    = addr_q[31:24];
                  n_addr  = {addr_q[23:0], 8'h00};
                end
                S_ADDR: begin
                  if (ab_cnt != 2'd3) begin
                    n_ab   = ab_cnt + 2'd1;
                    n_tx   = addr_q[31:24];
                    n_addr = {addr_q[23:0], 8'h00};
                  end else if (rnw_q) begin
                    n_state = S_DUMMY;
                    n_tx    = 8'h00;
                  end else next_data = 1'b1;
                end
                S_DUMMY: next_data = 1'b1;
                default: begin
                  if (len_cnt == '0) begin
                    n_state = S_GAP;
                    n_gap   = '0;
                    n_tx    = 8'h00;
                  end else next_data = 1'b1;
                end
              endcase
            end
          end
        end
        if (next_data) begin
          n_state = S_DATA;
          if (rnw_q) begin
            n_tx  = 8'h00;
            n_len = len_cnt - 1'b1;
          end else if (tx_valid_i) begin
            tx_ready = 1'b1;
            n_tx     = tx_data_i;
            n_len    = len_cnt - 1'b1;
          end else begin
            n_wait = 1'b1;
            n_tx   = 8'h00;
          end
        end
      end
      S_GAP: begin
        n_gap = gap_cnt + 1'b1;
        if (gap_cnt == GW'(C_GAP)) n_state = S_IDLE;
      end
      default: n_state = S_IDLE;
    endcase
  end

  assign done_o     = (state == S_GAP) && (gap_cnt == GW'(C_GAP));
  assign busy_o     = (state != S_IDLE) && !done_o;
  assign csn_o      = !(state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA});
  assign sclk_o     = sclk_q;
  assign mosi_o     = tx_sh[7];
  assign tx_ready_o = tx_ready;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: byte-level SPI monitor, miso slave model, tx source.
module tb_spi_ram_master;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        start_i = 1'b0, rnw_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [15:0] len_i = '0;
  logic [7:0]  tx_data_i = '0;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o, rx_valid_o, busy_o, done_o, csn_o, sclk_o, mosi_o;
  logic [7:0]  rx_data_o;
  logic        miso_i = 1'b0;

  spi_ram_master #(.C_CLK_DIV(2), .C_LEN_BITS(16), .C_GAP(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .rnw_i(rnw_i), .addr_i(addr_i),
    .len_i(len_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .busy_o(busy_o), .done_o(done_o),
    .csn_o(csn_o), .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i));

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // monitor state
  int cyc = 0, rises = 0, csn_lo = 0, sclk_hi = 0, bad = 0, csn_rise = 0, busy_cnt = 0;
  int bitn = 0, sbit = 0;
  logic [7:0] mbyte = '0;
  logic [7:0] mq[$], rxq[$];
  int doneq[$], rdyq[$];
  logic csn_prev = 1'b1, sclk_prev = 1'b0;
  logic [7:0] resp[16];

  // tx source state
  logic [7:0] txbuf[4];
  int tx_len = 0, idx = 0, hold = 0, vrise = 0;
  bit tx_en = 0, stall_en = 0, ready_seen = 0, valid_prev = 0;

  function automatic logic sbit_val(input int k);
    logic [7:0] b;
    b = resp[(k >> 3) & 15];
    return b[3'(7 - (k % 8))];
  endfunction

  always @(negedge clk_i) begin
    cyc++;
    if (!csn_o && csn_prev) begin
      bitn = 0; sbit = 0; miso_i = sbit_val(0);
    end
    if (!csn_o) csn_lo++;
    if (sclk_o) sclk_hi++;
    if (sclk_o && csn_o) bad++;
    if (csn_o && !csn_prev) csn_rise++;
    if (sclk_o && !sclk_prev) begin
      rises++; mbyte = {mbyte[6:0], mosi_o}; bitn++;
      if (bitn % 8 == 0) mq.push_back(mbyte);
    end
    if (!sclk_o && sclk_prev && !csn_o) begin
      sbit++; miso_i = sbit_val(sbit);
    end
    if (tx_ready_o) begin ready_seen = 1; rdyq.push_back(cyc); end
    if (rx_valid_o) rxq.push_back(rx_data_o);
    if (done_o) doneq.push_back(cyc);
    if (busy_o) busy_cnt++;
    csn_prev = csn_o; sclk_prev = sclk_o;
  end

  always @(posedge clk_i) begin
    #1;
    if (ready_seen) begin
      ready_seen = 0; idx++;
      if (stall_en && idx == 1) hold = 52;
    end
    if (hold > 0) hold--;
    tx_valid_i = tx_en && (idx < tx_len) && (hold == 0);
    tx_data_i  = (idx < 4) ? txbuf[idx] : 8'h00;
    if (tx_valid_i && !valid_prev) vrise = cyc + 1;
    valid_prev = tx_valid_i;
  end

  task automatic clear();
    @(posedge clk_i); #2;
    rises = 0; csn_lo = 0; sclk_hi = 0; bad = 0; csn_rise = 0; busy_cnt = 0;
    mq.delete(); rxq.delete(); doneq.delete(); rdyq.delete();
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
  endtask

  task automatic tx_setup(input int n, input logic [7:0] b0, input logic [7:0] b1, input bit stall);
    txbuf[0] = b0; txbuf[1] = b1; txbuf[2] = 8'h00; txbuf[3] = 8'h00;
    tx_len = n; idx = 0; hold = 0; stall_en = stall; tx_en = (n > 0);
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (doneq.size() < n && t < 5000) begin @(posedge clk_i); t++; end
    chk("done_timeout", 64'(doneq.size() >= n), 64'd1);
    repeat (3) @(posedge clk_i);
  endtask

  // raise start for one cycle, then scramble the inputs to show they were latched
  task automatic run_frame(input bit rnw, input logic [31:0] a, input int len, output int s);
    @(posedge clk_i); #2;
    start_i = 1; rnw_i = rnw; addr_i = a; len_i = 16'(len); s = cyc + 1;
    @(posedge clk_i); #2;
    start_i = 0; rnw_i = ~rnw; addr_i = 32'hDEADBEEF; len_i = 16'd7;
    wait_done(1);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp[$], input logic [7:0] got[$]);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    int s;
    logic [7:0] e[$];
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_csn", 64'(csn_o), 64'd1);
    chk("rst_sclk", 64'(sclk_o), 64'd0);
    chk("rst_mosi", 64'(mosi_o), 64'd0);
    chk("rst_busy_done", 64'({busy_o, done_o, tx_ready_o, rx_valid_o}), 64'd0);
    chk("rst_rxdata", 64'(rx_data_o), 64'd0);
    rst_ni = 1;

    // unstalled write
    clear(); tx_setup(2, 8'hAA, 8'h55, 0);
    run_frame(0, 32'h00000123, 2, s);
    e = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'hAA, 8'h55};
    chk_bytes("wr_mosi", e, mq);
    chk("wr_rises", 64'(rises), 64'd56);
    chk("wr_csn_lo", 64'(csn_lo), 64'd224);
    chk("wr_sclk_hi", 64'(sclk_hi), 64'd112);
    chk("wr_ready", 64'(rdyq.size()), 64'd2);
    chk("wr_done_cnt", 64'(doneq.size()), 64'd1);
    if (doneq.size() > 0) chk("wr_done_lat", 64'(doneq[0] - s), 64'd229);
    chk("wr_rx_none", 64'(rxq.size()), 64'd0);
    chk("wr_sclk_csn", 64'(bad), 64'd0);

    // read with dummy byte
    clear(); tx_setup(0, 8'h00, 8'h00, 0);
    resp[6] = 8'h11; resp[7] = 8'h22; resp[8] = 8'h33;
    run_frame(1, 32'h00000080, 3, s);
    e = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_bytes("rd_mosi", e, mq);
    e = '{8'h11, 8'h22, 8'h33};
    chk_bytes("rd_rx", e, rxq);
    chk("rd_rises", 64'(rises), 64'd72);
    chk("rd_csn_lo", 64'(csn_lo), 64'd288);
    if (doneq.size() > 0) chk("rd_done_lat", 64'(doneq[0] - s), 64'd293);

    // write with source stall before the second data byte
    clear(); tx_setup(2, 8'hAA, 8'h55, 1);
    run_frame(0, 32'h00000123, 2, s);
    e = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'hAA, 8'h55};
    chk_bytes("st_mosi", e, mq);
    chk("st_csn_lo", 64'(csn_lo), 64'd244);
    chk("st_sclk_hi", 64'(sclk_hi), 64'd112);
    chk("st_csn_rise", 64'(csn_rise), 64'd1);
    chk("st_ready", 64'(rdyq.size()), 64'd2);
    if (rdyq.size() > 1) chk("st_ready_at_valid", 64'(rdyq[1]), 64'(vrise));

    // zero-length frame
    clear(); tx_setup(0, 8'h00, 8'h00, 0);
    run_frame(0, 32'h00000010, 0, s);
    chk("z_csn_lo", 64'(csn_lo), 64'd0);
    if (doneq.size() > 0) chk("z_done_lat", 64'(doneq[0] - s), 64'd5);
    chk("z_busy", 64'(busy_cnt), 64'd4);

    // reset during the first address byte
    clear(); tx_setup(2, 8'h11, 8'h22, 0);
    @(posedge clk_i); #2; start_i = 1; rnw_i = 0; addr_i = 32'h12345678; len_i = 16'd2;
    @(posedge clk_i); #2; start_i = 0;
    repeat (45) @(posedge clk_i);
    #2; rst_ni = 0; #1;
    chk("mr_csn", 64'(csn_o), 64'd1);
    chk("mr_sclk", 64'(sclk_o), 64'd0);
    chk("mr_busy", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk_i);
    chk("mr_no_done", 64'(doneq.size()), 64'd0);
    #2; rst_ni = 1;
    clear(); tx_setup(1, 8'h5A, 8'h00, 0);
    run_frame(0, 32'hFF000000, 1, s);
    e = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h5A};
    chk_bytes("mr_mosi", e, mq);
    if (doneq.size() > 0) chk("mr_done_lat", 64'(doneq[0] - s), 64'd197);

    // start while busy and on the done cycle ignored; next cycle accepted
    clear(); tx_setup(0, 8'h00, 8'h00, 0);
    @(posedge clk_i); #2; start_i = 1; rnw_i = 0; len_i = 16'd0; s = cyc + 1;
    @(posedge clk_i); #2; start_i = 0;
    @(posedge clk_i); #2; start_i = 1; rnw_i = 1; len_i = 16'd3;
    @(posedge clk_i); #2; start_i = 0; rnw_i = 0; len_i = 16'd0;
    @(posedge clk_i); #2;
    @(posedge clk_i); #2; start_i = 1;
    @(posedge clk_i); #2;
    @(posedge clk_i); #2; start_i = 0;
    wait_done(2);
    chk("bz_done_cnt", 64'(doneq.size()), 64'd2);
    if (doneq.size() > 1) begin
      chk("bz_done0", 64'(doneq[0] - s), 64'd5);
      chk("bz_done1", 64'(doneq[1] - s), 64'd11);
    end
    chk("bz_csn_lo", 64'(csn_lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
